// File: rtl/alu_operand_stage.sv
// ----------------------------------------------------------------------------
// alu_operand_stage
//   Operand-select stage in front of the ALU. It decodes the operand selects,
//   resolves EX/MEM and WB forwarding, and extends the immediate and shift
//   amount. It stalls one extra cycle on a load-use hazard and registers the
//   operands behind a valid/ready handshake.
//
// Ports
//   w_clk, w_rst             clock, asynchronous active-high reset
//   w_in_valid / w_in_ready  upstream handshake
//   w_mem_op, w_imm_op,
//   w_shift_op, w_imm_signed decoded op class and immediate extension mode
//   w_rs_*, w_rt_*           register-file read addresses and data
//   w_imm, w_shamt           instruction immediate and shift amount
//   w_exm_*                  EX/MEM forward source (w_exm_is_load marks a load)
//   w_wb_*                   WB forward source
//   w_flush                  drops the held output and blocks capture
//   w_cnt_clr                synchronous clear of the hazard counter
//   w_out_valid/w_out_ready  downstream handshake
//   w_alu_lhs/rhs(_ctrl)     registered operands and operand selects
//   w_hazard_cnt             saturating load-use hazard count
// ----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                w_clk,
    input  logic                w_rst,
    input  logic                w_in_valid,
    output logic                w_in_ready,
    input  logic                w_mem_op,
    input  logic                w_imm_op,
    input  logic                w_shift_op,
    input  logic                w_imm_signed,
    input  logic [REG_AW-1:0]   w_rs_addr,
    input  logic [REG_AW-1:0]   w_rt_addr,
    input  logic [DATA_W-1:0]   w_rs_data,
    input  logic [DATA_W-1:0]   w_rt_data,
    input  logic [IMM_W-1:0]    w_imm,
    input  logic [SHAMT_W-1:0]  w_shamt,
    input  logic                w_exm_wr_en,
    input  logic [REG_AW-1:0]   w_exm_wr_addr,
    input  logic [DATA_W-1:0]   w_exm_wr_data,
    input  logic                w_exm_is_load,
    input  logic                w_wb_wr_en,
    input  logic [REG_AW-1:0]   w_wb_wr_addr,
    input  logic [DATA_W-1:0]   w_wb_wr_data,
    input  logic                w_flush,
    input  logic                w_cnt_clr,
    output logic                w_out_valid,
    input  logic                w_out_ready,
    output logic [DATA_W-1:0]   w_alu_lhs,
    output logic [DATA_W-1:0]   w_alu_rhs,
    output logic                w_alu_lhs_ctrl,
    output logic [1:0]          w_alu_rhs_ctrl,
    output logic [CNT_W-1:0]    w_hazard_cnt
);

    typedef enum logic {RUN, HAZ} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_lhs, r_rhs;
    logic               r_lhs_ctrl;
    logic [1:0]         r_rhs_ctrl;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_lhs_ctrl;
    logic [1:0]         w_rhs_ctrl;
    logic [DATA_W-1:0]  w_imm_ext, w_shamt_ext, w_rs_fwd, w_rt_fwd;
    logic [DATA_W-1:0]  w_lhs, w_rhs;
    logic               w_rs_used, w_rt_used, w_hazard, w_fire, w_enter_haz;

    // EX/MEM wins over WB; register 0 is never forwarded.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              exm_en,
        input logic [REG_AW-1:0] exm_addr,
        input logic [DATA_W-1:0] exm_data,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data
    );
        if (addr != '0 && exm_en && exm_addr == addr)
            return exm_data;
        else if (addr != '0 && wb_en && wb_addr == addr)
            return wb_data;
        else
            return rf_data;
    endfunction

    // Operand select decode: shift > mem > other.
    always_comb begin
        w_lhs_ctrl = 1'b0;
        w_rhs_ctrl = 2'b01;
        if (w_shift_op) begin
            w_lhs_ctrl = 1'b1;
            w_rhs_ctrl = w_imm_op ? 2'b10 : 2'b00;
        end else if (w_mem_op) begin
            w_rhs_ctrl = 2'b11;
        end else begin
            w_rhs_ctrl = w_imm_op ? 2'b11 : 2'b01;
        end
    end

    // Address arithmetic for memory ops always needs a sign-extended offset.
    assign w_imm_ext   = (w_mem_op || w_imm_signed) ? DATA_W'($signed(w_imm)) : DATA_W'(w_imm);
    assign w_shamt_ext = DATA_W'(w_shamt);

    assign w_rs_fwd = fwd_sel(w_rs_addr, w_rs_data, w_exm_wr_en, w_exm_wr_addr, w_exm_wr_data,
                              w_wb_wr_en, w_wb_wr_addr, w_wb_wr_data);
    assign w_rt_fwd = fwd_sel(w_rt_addr, w_rt_data, w_exm_wr_en, w_exm_wr_addr, w_exm_wr_data,
                              w_wb_wr_en, w_wb_wr_addr, w_wb_wr_data);

    always_comb begin
        w_lhs = w_lhs_ctrl ? w_rt_fwd : w_rs_fwd;
        unique case (w_rhs_ctrl)
            2'b00:   w_rhs = w_rs_fwd;
            2'b01:   w_rhs = w_rt_fwd;
            2'b10:   w_rhs = w_shamt_ext;
            default: w_rhs = w_imm_ext;
        endcase
    end

    // A hazard only counts against an operand the op actually reads.
    assign w_rs_used = !w_lhs_ctrl || (w_rhs_ctrl == 2'b00);
    assign w_rt_used =  w_lhs_ctrl || (w_rhs_ctrl == 2'b01);
    assign w_hazard  = w_in_valid && w_exm_wr_en && w_exm_is_load && (w_exm_wr_addr != '0) &&
                       ((w_rs_used && w_exm_wr_addr == w_rs_addr) ||
                        (w_rt_used && w_exm_wr_addr == w_rt_addr));

    // FSM: state register
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = RUN;
        if (r_state == RUN && w_hazard && !w_flush)
            w_state_nxt = HAZ;
    end

    // FSM: outputs
    always_comb begin
        w_in_ready  = (r_state == RUN) && !w_hazard && !w_flush && (!r_out_valid || w_out_ready);
        w_enter_haz = (r_state == RUN) && (w_state_nxt == HAZ);
    end

    assign w_fire = w_in_valid && w_in_ready;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_out_valid <= 1'b0;
            r_lhs       <= '0;
            r_rhs       <= '0;
            r_lhs_ctrl  <= 1'b0;
            r_rhs_ctrl  <= '0;
        end else begin
            if (w_flush)          r_out_valid <= 1'b0;
            else if (w_fire)      r_out_valid <= 1'b1;
            else if (w_out_ready) r_out_valid <= 1'b0;
            if (w_fire) begin
                r_lhs      <= w_lhs;
                r_rhs      <= w_rhs;
                r_lhs_ctrl <= w_lhs_ctrl;
                r_rhs_ctrl <= w_rhs_ctrl;
            end
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst)
            r_cnt <= '0;
        else if (w_cnt_clr)
            r_cnt <= '0;
        else if (w_enter_haz && r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_out_valid    = r_out_valid;
    assign w_alu_lhs      = r_lhs;
    assign w_alu_rhs      = r_rhs;
    assign w_alu_lhs_ctrl = r_lhs_ctrl;
    assign w_alu_rhs_ctrl = r_rhs_ctrl;
    assign w_hazard_cnt   = r_cnt;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    localparam int CW = 3;

    logic        w_clk, w_rst;
    logic        w_in_valid, w_in_ready;
    logic        w_mem_op, w_imm_op, w_shift_op, w_imm_signed;
    logic [4:0]  w_rs_addr, w_rt_addr;
    logic [31:0] w_rs_data, w_rt_data;
    logic [15:0] w_imm;
    logic [4:0]  w_shamt;
    logic        w_exm_wr_en, w_exm_is_load;
    logic [4:0]  w_exm_wr_addr;
    logic [31:0] w_exm_wr_data;
    logic        w_wb_wr_en;
    logic [4:0]  w_wb_wr_addr;
    logic [31:0] w_wb_wr_data;
    logic        w_flush, w_cnt_clr;
    logic        w_out_valid, w_out_ready;
    logic [31:0] w_alu_lhs, w_alu_rhs;
    logic        w_alu_lhs_ctrl;
    logic [1:0]  w_alu_rhs_ctrl;
    logic [CW-1:0] w_hazard_cnt;

    alu_operand_stage #(.DATA_W(32), .IMM_W(16), .SHAMT_W(5), .REG_AW(5), .CNT_W(CW)) dut (
        .w_clk(w_clk), .w_rst(w_rst),
        .w_in_valid(w_in_valid), .w_in_ready(w_in_ready),
        .w_mem_op(w_mem_op), .w_imm_op(w_imm_op), .w_shift_op(w_shift_op), .w_imm_signed(w_imm_signed),
        .w_rs_addr(w_rs_addr), .w_rt_addr(w_rt_addr), .w_rs_data(w_rs_data), .w_rt_data(w_rt_data),
        .w_imm(w_imm), .w_shamt(w_shamt),
        .w_exm_wr_en(w_exm_wr_en), .w_exm_wr_addr(w_exm_wr_addr), .w_exm_wr_data(w_exm_wr_data),
        .w_exm_is_load(w_exm_is_load),
        .w_wb_wr_en(w_wb_wr_en), .w_wb_wr_addr(w_wb_wr_addr), .w_wb_wr_data(w_wb_wr_data),
        .w_flush(w_flush), .w_cnt_clr(w_cnt_clr),
        .w_out_valid(w_out_valid), .w_out_ready(w_out_ready),
        .w_alu_lhs(w_alu_lhs), .w_alu_rhs(w_alu_rhs),
        .w_alu_lhs_ctrl(w_alu_lhs_ctrl), .w_alu_rhs_ctrl(w_alu_rhs_ctrl),
        .w_hazard_cnt(w_hazard_cnt)
    );

    typedef struct packed {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic        lc;
        logic [1:0]  rc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] lhs, input logic [31:0] rhs, input logic lc, input logic [1:0] rc);
        exp_t e;
        e.lhs = lhs; e.rhs = rhs; e.lc = lc; e.rc = rc;
        q.push_back(e);
    endtask

    // Scoreboard monitor: every accepted output is matched against the queue head.
    always @(negedge w_clk) begin
        if (!w_rst && w_out_valid && w_out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'(w_out_valid), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_lhs", 64'(w_alu_lhs), 64'(e.lhs));
                chk("sb_rhs", 64'(w_alu_rhs), 64'(e.rhs));
                chk("sb_lhs_ctrl", 64'(w_alu_lhs_ctrl), 64'(e.lc));
                chk("sb_rhs_ctrl", 64'(w_alu_rhs_ctrl), 64'(e.rc));
            end
        end
    end

    task automatic idle();
        w_in_valid = 0; w_mem_op = 0; w_imm_op = 0; w_shift_op = 0; w_imm_signed = 0;
        w_rs_addr = 0; w_rt_addr = 0; w_rs_data = 0; w_rt_data = 0; w_imm = 0; w_shamt = 0;
        w_exm_wr_en = 0; w_exm_wr_addr = 0; w_exm_wr_data = 0; w_exm_is_load = 0;
        w_wb_wr_en = 0; w_wb_wr_addr = 0; w_wb_wr_data = 0; w_flush = 0; w_cnt_clr = 0;
    endtask

    task automatic op(input logic sh, input logic mem, input logic im, input logic sg,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [31:0] rsd, input logic [31:0] rtd,
                      input logic [15:0] imm, input logic [4:0] shamt);
        w_in_valid = 1; w_shift_op = sh; w_mem_op = mem; w_imm_op = im; w_imm_signed = sg;
        w_rs_addr = rs; w_rt_addr = rt; w_rs_data = rsd; w_rt_data = rtd; w_imm = imm; w_shamt = shamt;
    endtask

    task automatic exm(input logic en, input logic [4:0] a, input logic [31:0] d, input logic ld);
        w_exm_wr_en = en; w_exm_wr_addr = a; w_exm_wr_data = d; w_exm_is_load = ld;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        w_wb_wr_en = en; w_wb_wr_addr = a; w_wb_wr_data = d;
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    // Issue an op expected to be accepted this cycle.
    task automatic issue(input string nm, input logic [31:0] lhs, input logic [31:0] rhs,
                         input logic lc, input logic [1:0] rc);
        #1;
        chk(nm, 64'(w_in_ready), 64'd1);
        push(lhs, rhs, lc, rc);
        step();
    endtask

    task automatic load_use_hazard();
        idle();
        op(0, 0, 0, 0, 5'd1, 5'd2, 32'h1, 32'h2, 16'h0, 5'h0);
        exm(1, 5'd1, 32'hDEAD, 1);
        step();
        idle();
        step();
    endtask

    initial begin
        exp_t saved;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t saved;
        idle();
        w_out_ready = 1;
        w_rst = 1;
        repeat (2) @(posedge w_clk);
        #1;
        chk("rst_out_valid", 64'(w_out_valid), 64'd0);
        chk("rst_lhs", 64'(w_alu_lhs), 64'd0);
        chk("rst_rhs", 64'(w_alu_rhs), 64'd0);
        chk("rst_ctrls", 64'({w_alu_lhs_ctrl, w_alu_rhs_ctrl}), 64'd0);
        chk("rst_cnt", 64'(w_hazard_cnt), 64'd0);
        w_rst = 0;

        // Forwarding: EX/MEM to rs, WB to rt
        op(0, 0, 0, 0, 5'd1, 5'd2, 32'h11, 32'h22, 16'h0, 5'h0);
        exm(1, 5'd1, 32'h55, 0);
        wb(1, 5'd2, 32'h66);
        issue("rdy_add", 32'h55, 32'h66, 0, 2'b01);
        chk("latency_valid", 64'(w_out_valid), 64'd1);
        // EX/MEM beats WB on the same address
        idle();
        op(0, 0, 0, 0, 5'd3, 5'd4, 32'h33, 32'h44, 16'h0, 5'h0);
        exm(1, 5'd3, 32'hA, 0);
        wb(1, 5'd3, 32'hB);
        issue("rdy_prio", 32'hA, 32'h44, 0, 2'b01);
        // Address 0 never forwards
        idle();
        op(0, 0, 0, 0, 5'd0, 5'd6, 32'h5, 32'h66, 16'h0, 5'h0);
        exm(1, 5'd0, 32'hEE, 0);
        wb(1, 5'd6, 32'h60);
        issue("rdy_r0", 32'h5, 32'h60, 0, 2'b01);

        // Shift / mem / immediate forms
        idle(); op(1, 0, 1, 0, 5'd0, 5'd5, 32'h0, 32'h1, 16'h0, 5'd4);
        issue("rdy_sll", 32'h1, 32'h4, 1, 2'b10);
        idle(); op(1, 0, 0, 0, 5'd7, 5'd8, 32'h3, 32'h80, 16'h0, 5'd0);
        issue("rdy_sllv", 32'h80, 32'h3, 1, 2'b00);
        idle(); op(0, 1, 1, 0, 5'd9, 5'd0, 32'h1000, 32'h0, 16'hFFFC, 5'd0);
        issue("rdy_mem", 32'h1000, 32'hFFFFFFFC, 0, 2'b11);
        idle(); op(0, 0, 1, 0, 5'd9, 5'd0, 32'h7, 32'h0, 16'h8001, 5'd0);
        issue("rdy_zext", 32'h7, 32'h00008001, 0, 2'b11);
        idle(); op(0, 0, 1, 1, 5'd9, 5'd0, 32'h7, 32'h0, 16'h8001, 5'd0);
        issue("rdy_sext", 32'h7, 32'hFFFF8001, 0, 2'b11);
        idle(); op(1, 0, 1, 0, 5'd0, 5'd10, 32'h0, 32'h2, 16'h0, 5'h1F);
        issue("rdy_shamt", 32'h2, 32'h1F, 1, 2'b10);
        idle(); step();

        // Load-use hazard: two cycles of in_ready=0, then capture from WB
        op(0, 0, 0, 0, 5'd1, 5'd2, 32'h1, 32'h2, 16'h0, 5'h0);
        exm(1, 5'd1, 32'hDEAD, 1);
        #1; chk("haz_rdy0", 64'(w_in_ready), 64'd0);
        step();
        chk("haz_cnt1", 64'(w_hazard_cnt), 64'd1);
        exm(0, 5'd0, 32'h0, 0);
        wb(1, 5'd1, 32'h99);
        #1; chk("haz_rdy1", 64'(w_in_ready), 64'd0);
        step();
        issue("haz_after", 32'h99, 32'h2, 0, 2'b01);
        // Load to an unused operand is not a hazard
        idle();
        op(0, 0, 1, 0, 5'd1, 5'd2, 32'h10, 32'h0, 16'h5, 5'h0);
        exm(1, 5'd2, 32'hBEEF, 1);
        issue("nohaz_unused", 32'h10, 32'h5, 0, 2'b11);
        chk("nohaz_cnt", 64'(w_hazard_cnt), 64'd1);
        idle(); step();

        // Backpressure then back-to-back
        w_out_ready = 0;
        op(0, 0, 0, 0, 5'd11, 5'd12, 32'hA1, 32'hA2, 16'h0, 5'h0);
        issue("bp_first", 32'hA1, 32'hA2, 0, 2'b01);
        op(0, 0, 0, 0, 5'd13, 5'd14, 32'hB1, 32'hB2, 16'h0, 5'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy", 64'(w_in_ready), 64'd0);
            chk("bp_valid", 64'(w_out_valid), 64'd1);
            chk("bp_lhs", 64'(w_alu_lhs), 64'h0A1);
            chk("bp_rhs", 64'(w_alu_rhs), 64'h0A2);
            step();
        end
        w_out_ready = 1;
        issue("b2b_1", 32'hB1, 32'hB2, 0, 2'b01);
        op(0, 0, 0, 0, 5'd15, 5'd16, 32'hC1, 32'hC2, 16'h0, 5'h0);
        issue("b2b_2", 32'hC1, 32'hC2, 0, 2'b01);
        idle(); step(); step();

        // Flush with held output and incoming op
        w_out_ready = 0;
        op(0, 0, 0, 0, 5'd17, 5'd18, 32'hF1, 32'hF2, 16'h0, 5'h0);
        issue("fl_first", 32'hF1, 32'hF2, 0, 2'b01);
        op(0, 0, 0, 0, 5'd19, 5'd20, 32'hD1, 32'hD2, 16'h0, 5'h0);
        w_flush = 1;
        #1; chk("fl_rdy", 64'(w_in_ready), 64'd0);
        step();
        saved = q.pop_front();
        chk("fl_valid", 64'(w_out_valid), 64'd0);
        chk("fl_nocap", 64'(w_alu_lhs), 64'(saved.lhs));
        idle(); w_out_ready = 1; step();

        // Flush overrides a hazard: no HAZ entry, no count
        op(0, 0, 0, 0, 5'd1, 5'd2, 32'h1, 32'h2, 16'h0, 5'h0);
        exm(1, 5'd1, 32'hDEAD, 1);
        w_flush = 1;
        step();
        chk("flhaz_cnt", 64'(w_hazard_cnt), 64'd1);
        w_flush = 0;
        exm(0, 5'd0, 32'h0, 0);
        issue("flhaz_run", 32'h1, 32'h2, 0, 2'b01);
        idle(); step();

        // Saturation and clear
        for (int i = 0; i < 6; i++) load_use_hazard();
        chk("sat_cnt7", 64'(w_hazard_cnt), 64'd7);
        load_use_hazard();
        chk("sat_hold", 64'(w_hazard_cnt), 64'd7);
        op(0, 0, 0, 0, 5'd1, 5'd2, 32'h1, 32'h2, 16'h0, 5'h0);
        exm(1, 5'd1, 32'hDEAD, 1);
        w_cnt_clr = 1;
        step();
        chk("clr_wins", 64'(w_hazard_cnt), 64'd0);
        idle(); step();

        // Reset mid-handshake, then capture on first edge after release
        w_out_ready = 0;
        op(0, 0, 0, 0, 5'd21, 5'd22, 32'h71, 32'h72, 16'h0, 5'h0);
        issue("rs_first", 32'h71, 32'h72, 0, 2'b01);
        idle();
        #2; w_rst = 1;
        #1;
        chk("arst_valid", 64'(w_out_valid), 64'd0);
        chk("arst_lhs", 64'(w_alu_lhs), 64'd0);
        chk("arst_rhs", 64'(w_alu_rhs), 64'd0);
        void'(q.pop_front());
        w_rst = 0;
        w_out_ready = 1;
        op(0, 0, 0, 0, 5'd23, 5'd24, 32'h81, 32'h82, 16'h0, 5'h0);
        #2;
        chk("post_rst_rdy", 64'(w_in_ready), 64'd1);
        push(32'h81, 32'h82, 0, 2'b01);
        step();
        chk("post_rst_valid", 64'(w_out_valid), 64'd1);
        idle(); step(); step();

        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, ALU operand and register data width.
REQ-002 Parameter IMM_W, default 16, instruction immediate width (IMM_W <= DATA_W).
REQ-003 Parameter SHAMT_W, default 5, shift-amount width.
REQ-004 Parameter REG_AW, default 5, register address width.
REQ-005 Parameter CNT_W, default 16, hazard counter width.
REQ-006 w_clk  in  1  single clock; all state updates on its rising edge.
REQ-007 w_rst  in  1  reset, asynchronous, active-high.
REQ-008 w_in_valid in 1 upstream instruction valid; w_in_ready out 1 stage accepts.
REQ-009 w_mem_op, w_imm_op, w_shift_op, w_imm_signed  in  1 each  decoded op class and immediate extension mode.
REQ-010 w_rs_addr, w_rt_addr  in  REG_AW; w_rs_data, w_rt_data  in  DATA_W  register-file reads.
REQ-011 w_imm in IMM_W; w_shamt in SHAMT_W  instruction fields.
REQ-012 w_exm_wr_en in 1, w_exm_wr_addr in REG_AW, w_exm_wr_data in DATA_W, w_exm_is_load in 1  EX/MEM forward source.
REQ-013 w_wb_wr_en in 1, w_wb_wr_addr in REG_AW, w_wb_wr_data in DATA_W  WB forward source.
REQ-014 w_flush  in  1  pipeline flush.
REQ-015 w_cnt_clr  in  1  synchronous clear of hazard counter.
REQ-016 w_out_valid out 1; w_out_ready in 1  downstream handshake.
REQ-017 w_alu_lhs, w_alu_rhs  out  DATA_W  registered operands; w_alu_lhs_ctrl out 1, w_alu_rhs_ctrl out 2  registered selects.
REQ-018 w_hazard_cnt  out  CNT_W  load-use hazard count.

Function
REQ-019 Select priority: shift_op > mem_op > other; shift: lhs_ctrl=1, rhs_ctrl=10 if imm_op else 00; mem: lhs_ctrl=0, rhs_ctrl=11; other: lhs_ctrl=0, rhs_ctrl=11 if imm_op else 01.
REQ-020 lhs_ctrl 0=rs operand, 1=rt operand; rhs_ctrl 00=rs, 01=rt, 10=shamt zero-extended to DATA_W, 11=imm extended to DATA_W.
REQ-021 Imm extension: mem_op always sign-extends; otherwise sign-extend if w_imm_signed else zero-extend.
REQ-022 Forwarded rs/rt value: EX/MEM data if exm_wr_en and addr match; else WB data if wb_wr_en and match; else regfile data; address 0 never forwards.
REQ-023 rs used iff lhs_ctrl=0 or rhs_ctrl=00; rt used iff lhs_ctrl=1 or rhs_ctrl=01.
REQ-024 hazard = in_valid and exm_wr_en and exm_is_load and exm_wr_addr!=0 and matches a used operand address.
REQ-025 FSM states RUN, HAZ; RUN->HAZ when state RUN, hazard, no flush; HAZ->RUN unconditionally after exactly one cycle.
REQ-026 w_in_ready = (state==RUN) and !hazard and !w_flush and (!w_out_valid or w_out_ready), combinational.
REQ-027 fire = in_valid and in_ready; on fire operand and ctrl registers load next edge; latency 1 cycle input to output.
REQ-028 w_out_valid: set on fire; cleared when w_out_ready and no fire; held with data stable while valid and !ready.
REQ-029 Simultaneous out_ready and fire: new data replaces old, out_valid stays 1 (full throughput, one op per cycle).
REQ-030 w_flush: next edge out_valid=0, state=RUN, no capture that cycle; flush overrides fire and hazard.
REQ-031 w_hazard_cnt increments by 1 on each RUN->HAZ transition, saturates at 2^CNT_W-1, never wraps.
REQ-032 w_cnt_clr zeroes the counter next edge; clear wins over simultaneous increment.
REQ-033 Operand arithmetic: no arithmetic beyond extension; shamt upper bits zero.

Reset
REQ-034 w_rst asserted: immediately out_valid=0, alu_lhs=alu_rhs=0, ctrls=0, state=RUN, hazard_cnt=0; reset mid-handshake discards held op.
REQ-035 First capture possible on first rising edge after w_rst deasserts.

Verification
REQ-036 Add r3,r1,r2 (rs=1,rt=2), EX/MEM writes r1=0x55, WB writes r2=0x66 -> lhs=0x55, rhs=0x66, lhs_ctrl=0, rhs_ctrl=01, out_valid one cycle later.
REQ-037 Load r1 in EX/MEM, next op uses r1 -> in_ready=0 two cycles (hazard+HAZ), hazard_cnt 0->1, op captured after.
REQ-038 sll imm shamt=4, rt=r5 data 0x1 -> lhs=0x1, rhs=0x4, ctrls 1/10; mem_op imm=0xFFFC -> rhs=0xFFFFFFFC regardless of imm_signed.
REQ-039 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; ready returns -> back-to-back ops every cycle.
REQ-040 Flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, no capture; counter at max plus hazard -> stays max; cnt_clr -> 0.
